// File: rtl/decode_queue.sv
// Instruction-byte prefetch FIFO and 1-3 byte length assembler feeding decode.
// Define DECODE_QUEUE_COUNT_EN to add the instr_count accepted-instruction counter port.
module decode_queue #(
   parameter int unsigned       DEPTH    = 4,
   parameter int unsigned       ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk_m2,
   input  logic              rst,
   input  logic              rdy,
   input  logic [7:0]        in_byte,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   input  logic [ADDR_W-1:0] flush_pc,
   output logic [7:0]        out_op,
   output logic [7:0]        out_lo,
   output logic [7:0]        out_hi,
   output logic [1:0]        out_len,
   output logic [ADDR_W-1:0] out_pc,
   output logic              out_valid,
`ifdef DECODE_QUEUE_COUNT_EN
   output logic [31:0]       instr_count,
`endif
   input  logic              out_ready
);

   localparam int unsigned   PtrW = $clog2(DEPTH);
   localparam logic [PtrW:0] Full = DEPTH[PtrW:0];

   typedef enum logic [1:0] {SOp, SLo, SHi, SOut} state_e;

   state_e            state_q, state_d;
   logic [7:0]        mem [DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]     count_q;
   logic [ADDR_W-1:0] pc_q;
   logic [7:0]        head;
   logic [1:0]        op_len;
   logic              push, pop, fifo_ne, accept;

   assign head     = mem[rd_ptr_q];
   assign fifo_ne  = (count_q != '0);
   assign in_ready = rdy && (count_q != Full);
   assign push     = in_valid && in_ready && !flush;
   assign out_pc   = pc_q;

   // Length of the byte at the FIFO head, meaningful only when it is an opcode.
   always_comb begin
      if (head == 8'h00 || head == 8'h40 || head == 8'h60 ||
          (head[3:2] == 2'b10 && !head[0])) begin
         op_len = 2'd1;
      end else if (head == 8'h20 || head[4:2] == 3'b011 || head[4:2] == 3'b111 ||
                   (head[4:2] == 3'b110 && head[0])) begin
         op_len = 2'd3;
      end else begin
         op_len = 2'd2;
      end
   end

   always_ff @(posedge clk_m2 or posedge rst) begin
      if (rst) begin
         state_q <= SOp;
      end else if (flush) begin
         state_q <= SOp;
      end else if (rdy) begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         SOp:     if (fifo_ne) state_d = (op_len == 2'd1) ? SOut : SLo;
         SLo:     if (fifo_ne) state_d = (out_len == 2'd2) ? SOut : SHi;
         SHi:     if (fifo_ne) state_d = SOut;
         SOut:    if (out_ready) state_d = SOp;
         default: state_d = SOp;
      endcase
   end

   always_comb begin
      out_valid = (state_q == SOut);
      pop       = rdy && !flush && fifo_ne && (state_q != SOut);
      accept    = out_valid && out_ready && rdy && !flush;
   end

   always_ff @(posedge clk_m2) begin
      if (push) mem[wr_ptr_q] <= in_byte;
   end

   always_ff @(posedge clk_m2 or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      count_q <= count_q + 1'b1;
         else if (pop && !push) count_q <= count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_m2 or posedge rst) begin
      if (rst) begin
         out_op  <= '0;
         out_lo  <= '0;
         out_hi  <= '0;
         out_len <= '0;
         pc_q    <= RESET_PC;
      end else if (flush) begin
         out_op  <= '0;
         out_lo  <= '0;
         out_hi  <= '0;
         out_len <= '0;
         pc_q    <= flush_pc;
      end else begin
         if (pop) begin
            case (state_q)
               SOp: begin
                  out_op  <= head;
                  out_len <= op_len;
                  out_lo  <= '0;
                  out_hi  <= '0;
               end
               SLo:     out_lo <= head;
               SHi:     out_hi <= head;
               default: ;
            endcase
         end
         if (accept) pc_q <= pc_q + ADDR_W'(out_len);
      end
   end

`ifdef DECODE_QUEUE_COUNT_EN
   always_ff @(posedge clk_m2 or posedge rst) begin
      if (rst) begin
         instr_count <= '0;
      end else if (accept) begin
         instr_count <= instr_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: byte stream parsed by a reference length model.
module tb_decode_queue;

   localparam int unsigned DEPTH = 4;

   typedef struct {
      logic [7:0]  op;
      logic [7:0]  lo;
      logic [7:0]  hi;
      logic [1:0]  len;
      logic [15:0] pc;
   } exp_t;

   logic        clk_m2, rst, rdy, in_valid, in_ready, flush, out_valid, out_ready;
   logic [7:0]  in_byte, out_op, out_lo, out_hi;
   logic [1:0]  out_len;
   logic [15:0] flush_pc, out_pc;
`ifdef DECODE_QUEUE_COUNT_EN
   logic [31:0] instr_count;
`endif

   exp_t        exp_q[$];
   logic [7:0]  byte_q[$];
   exp_t        mon_e;
   int          n_tests, n_fail, hs_total, model_count;
   int          valid_pct, rdy_pct, or_mode;
   logic [15:0] m_pc;

   decode_queue #(
      .DEPTH   (DEPTH),
      .ADDR_W  (16),
      .RESET_PC(16'hC000)
   ) dut (
      .clk_m2   (clk_m2),
      .rst      (rst),
      .rdy      (rdy),
      .in_byte  (in_byte),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .flush    (flush),
      .flush_pc (flush_pc),
      .out_op   (out_op),
      .out_lo   (out_lo),
      .out_hi   (out_hi),
      .out_len  (out_len),
      .out_pc   (out_pc),
      .out_valid(out_valid),
`ifdef DECODE_QUEUE_COUNT_EN
      .instr_count(instr_count),
`endif
      .out_ready(out_ready)
   );

   initial clk_m2 = 1'b0;
   always #5 clk_m2 = ~clk_m2;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, want finish");
      $fatal(1, "watchdog");
   end

   function automatic int ref_len(input logic [7:0] op);
      if (op == 8'h00 || op == 8'h40 || op == 8'h60) return 1;
      casez (op)
         8'b????10?0:                                  return 1;
         8'h20, 8'b???011??, 8'b???111??, 8'b???110?1: return 3;
         default:                                      return 2;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic add_instr(input logic [7:0] op, input logic [7:0] lo, input logic [7:0] hi);
      exp_t e;
      int len = ref_len(op);
      e.op  = op;
      e.lo  = (len > 1) ? lo : 8'h00;
      e.hi  = (len > 2) ? hi : 8'h00;
      e.len = 2'(len);
      e.pc  = m_pc;
      exp_q.push_back(e);
      byte_q.push_back(op);
      if (len > 1) byte_q.push_back(lo);
      if (len > 2) byte_q.push_back(hi);
      m_pc += 16'(len);
   endtask

   // One clock: drive at posedge+1, sample at negedge, end at the next posedge+1.
   task automatic tick();
      logic took;
      rdy = ($urandom_range(0, 99) < rdy_pct);
      if (byte_q.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
         in_valid = 1'b1;
         in_byte  = byte_q[0];
      end else begin
         in_valid = 1'b0;
         in_byte  = 8'($urandom);
      end
      case (or_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk_m2);
      took = in_valid && in_ready && !flush;
      if (!rdy) check("rdy_low_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk_m2);
      #1;
      if (took) void'(byte_q.pop_front());
   endtask

   task automatic do_flush(input logic [15:0] pc);
      flush    = 1'b1;
      flush_pc = pc;
      exp_q.delete();
      byte_q.delete();
      m_pc     = pc;
      tick();
      flush    = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 3000) begin
         tick();
         k++;
      end
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d instructions pending, want 0", exp_q.size());
      end
   endtask

   task automatic wait_valid();
      int k = 0;
      while (!out_valid && k < 20) begin
         tick();
         k++;
      end
      check("wait_valid", 64'(out_valid), 64'd1);
   endtask

   always @(negedge clk_m2) begin
      if (!rst && out_valid && out_ready && rdy && !flush) begin
         hs_total++;
         model_count++;
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL instr: got op=%h pc=%h, want no instruction", out_op, out_pc);
         end else begin
            mon_e = exp_q.pop_front();
            if ({out_op, out_lo, out_hi, out_len, out_pc} !==
                {mon_e.op, mon_e.lo, mon_e.hi, mon_e.len, mon_e.pc}) begin
               n_fail++;
               $display("FAIL instr: got op=%h lo=%h hi=%h len=%0d pc=%h, want op=%h lo=%h hi=%h len=%0d pc=%h",
                        out_op, out_lo, out_hi, out_len, out_pc,
                        mon_e.op, mon_e.lo, mon_e.hi, mon_e.len, mon_e.pc);
            end
         end
      end
   end

   initial begin
      logic [63:0] snap;
      int          h0, d;
      n_tests = 0; n_fail = 0; hs_total = 0; model_count = 0;
      rst = 1'b1; rdy = 1'b1; in_valid = 1'b0; in_byte = '0; flush = 1'b0;
      flush_pc = '0; out_ready = 1'b0;
      valid_pct = 100; rdy_pct = 100; or_mode = 1; m_pc = 16'hC000;
      repeat (2) @(posedge clk_m2);
      #1;
      check("reset_out", 64'({out_valid, out_op, out_lo, out_hi, out_len}), 64'd0);
      check("reset_pc", 64'(out_pc), 64'hC000);
      check("reset_in_ready", 64'(in_ready), 64'd1);
      rst = 1'b0;

      add_instr(8'hA9, 8'h05, 8'h00);
      add_instr(8'hEA, 8'h00, 8'h00);
      add_instr(8'h4C, 8'h34, 8'h12);
      add_instr(8'hEA, 8'h00, 8'h00);
      drain();

      // Continuous one-byte instructions: one handshake every two cycles.
      do_flush(16'h1000);
      repeat (30) add_instr(8'hEA, 8'h00, 8'h00);
      h0 = hs_total;
      repeat (40) tick();
      d = hs_total - h0;
      n_tests++;
      if (d < 18 || d > 20) begin
         n_fail++;
         $display("FAIL throughput: got %0d handshakes in 40 cycles, want 18..20", d);
      end
      drain();

      // Fill the FIFO behind a stalled consumer.
      or_mode = 0;
      repeat (3) add_instr(8'h4C, 8'($urandom), 8'($urandom));
      repeat (DEPTH + 6) tick();
      check("full_in_ready", 64'(in_ready), 64'd0);
      check("full_out_valid", 64'(out_valid), 64'd1);
      or_mode = 2;
      drain();

      // rdy low mid-assembly freezes everything.
      or_mode = 0;
      add_instr(8'hAD, 8'h21, 8'h43);
      add_instr(8'hA9, 8'h77, 8'h00);
      tick();
      tick();
      check("rdy_mid_op", 64'(out_op), 64'hAD);
      snap = 64'({out_op, out_lo, out_hi, out_len, out_valid, out_pc});
      rdy_pct = 0;
      repeat (5) begin
         tick();
         check("rdy_hold", 64'({out_op, out_lo, out_hi, out_len, out_valid, out_pc}), snap);
      end
      rdy_pct = 100;
      or_mode = 2;
      drain();

      // Flush while waiting for the second operand.
      do_flush(16'h2000);
      or_mode = 0;
      byte_q.push_back(8'h4C);
      byte_q.push_back(8'h34);
      repeat (5) tick();
      check("shi_op", 64'(out_op), 64'h4C);
      check("shi_lo", 64'(out_lo), 64'h34);
      do_flush(16'h8000);
      check("flush_shi_valid", 64'(out_valid), 64'd0);
      check("flush_shi_op", 64'(out_op), 64'd0);
      check("flush_shi_in_ready", 64'(in_ready), 64'd1);
      add_instr(8'hA9, 8'h11, 8'h00);
      or_mode = 1;
      drain();

      // Flush in the same cycle as an accepting consumer drops the instruction.
      or_mode = 0;
      add_instr(8'h4C, 8'h00, 8'h90);
      wait_valid();
      or_mode = 1;
      do_flush(16'h8000);
      check("flush_sout_valid", 64'(out_valid), 64'd0);
      add_instr(8'hEA, 8'h00, 8'h00);
      drain();

      // Asynchronous reset mid-instruction.
      do_flush(16'h3000);
      or_mode = 0;
      byte_q.push_back(8'hA9);
      repeat (4) tick();
      check("slo_op", 64'(out_op), 64'hA9);
      #3 rst = 1'b1;
      #1;
      check("async_rst_out", 64'({out_valid, out_op, out_lo, out_hi, out_len}), 64'd0);
      check("async_rst_pc", 64'(out_pc), 64'hC000);
      byte_q.delete();
      exp_q.delete();
      m_pc = 16'hC000;
      model_count = 0;
      in_valid = 1'b0;
      @(posedge clk_m2);
      #1;
      rst = 1'b0;

      // Three accepted, flush, one accepted.
      or_mode = 2;
      repeat (3) add_instr(8'($urandom), 8'($urandom), 8'($urandom));
      drain();
      do_flush(16'h4000);
      add_instr(8'h20, 8'h00, 8'h50);
      drain();
`ifdef DECODE_QUEUE_COUNT_EN
      check("instr_count_4", 64'(instr_count), 64'd4);
`endif

      // Randomised stream with stalls on every interface.
      valid_pct = 70;
      rdy_pct = 85;
      repeat (80) add_instr(8'($urandom), 8'($urandom), 8'($urandom));
      drain();
      rdy_pct = 100;
`ifdef DECODE_QUEUE_COUNT_EN
      check("instr_count_end", 64'(instr_count), 64'(model_count));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised instruction-byte prefetch queue and length assembler between the bus fetch path and `decode`.
- Buffers fetched bytes in a DEPTH-entry FIFO and determines each instruction's length (1-3 bytes) from its opcode.
- Assembles opcode plus operand bytes into one word tagged with its PC and presents it on a valid/ready handshake.
- Flush input redirects the stream on a taken branch, jump or interrupt.

Parameters:
- DEPTH, 4: byte FIFO entries; power of two, minimum 2.
- ADDR_W, 16: PC width.
- RESET_PC, 16'h0000: PC loaded at reset; width ADDR_W.

Ports:
- clk_m2  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  CPU ready; low freezes all state except flush.
- in_byte  in  8  fetched byte.
- in_valid  in  1  in_byte valid.
- in_ready  out  1  queue can accept a byte.
- flush  in  1  discard queue and restart assembly.
- flush_pc  in  ADDR_W  PC of the first byte after flush.
- out_op  out  8  opcode.
- out_lo  out  8  first operand byte; 0 if length is 1.
- out_hi  out  8  second operand byte; 0 if length is below 3.
- out_len  out  2  instruction length, 1..3.
- out_pc  out  ADDR_W  address of the opcode.
- out_valid  out  1  assembled instruction available.
- out_ready  in  1  consumer accepts the instruction.

Behaviour:
- Reset (async, active-high): FIFO empty, count 0, FSM in S_OP, pc = RESET_PC, all out_* = 0, out_valid = 0.
- in_ready = rdy && (count < DEPTH). No same-cycle pass-through when full.
- Push occurs when in_valid && in_ready && !flush. The pointer wraps modulo DEPTH.
- Registered FIFO, no bypass: a byte pushed at edge N can be popped at edge N+1 at the earliest.
- At most one pop per cycle. Simultaneous push and pop leave count unchanged.
- Length decode, combinational on the popped opcode:
  - len1: 8'h00, 8'h40, 8'h60, or pattern ???_?10_?0.
  - len3: 8'h20, ???_011_??, ???_111_??, or ???_110_?1.
  - All other opcodes are len2.
- FSM, advancing only when rdy = 1:
  - S_OP: if FIFO non-empty, pop to out_op, latch len, clear lo/hi. Go to S_OUT if len1, else S_LO.
  - S_LO: if non-empty, pop to out_lo. Go to S_OUT if len2, else S_HI.
  - S_HI: if non-empty, pop to out_hi, go to S_OUT.
  - S_OUT: out_valid = 1 and out_* held stable. When out_ready, go to S_OP and set pc <= pc + len (mod 2^ADDR_W).
- An empty FIFO in S_OP, S_LO or S_HI holds the state; no bubble bytes are inserted.
- out_pc = pc for the whole instruction. out_valid is registered and is high only in S_OUT.
- Throughput: one len-L instruction per L+1 cycles when the queue is fed continuously.
- Flush has the highest priority and is honoured regardless of rdy. On the next edge:
  - FIFO emptied, count 0, FSM to S_OP, out_valid = 0, out_* = 0, pc <= flush_pc.
  - Any push in the same cycle is discarded.
  - A held out_valid instruction is dropped, even if out_ready is asserted in the same cycle.
- rdy = 0 with no flush: no push, no pop, no FSM or pc change; outputs hold.
- Reset asserted mid-instruction returns to the reset state immediately; partially assembled bytes are lost.

Optional Feature:
- Macro: DECODE_QUEUE_COUNT_EN.
- Defined:
  - Adds output port instr_count [31:0], reset to 0.
  - Increments by 1 on each accepted handshake (out_valid && out_ready && rdy && !flush) and wraps at 2^32.
  - Flush does not clear it.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC = 16'hC000, push A9,05 (LDA #) -> out_valid with op=A9, lo=05, hi=00, len=2, pc=C000 at earliest 3 edges after the first push edge. Accept it -> next pc = C002.
- Push 4C,34,12 then EA with out_ready = 1 -> {4C,34,12,len3,pc} followed by {EA,00,00,len1,pc+3}. Stream 8'hEA continuously -> one instruction per 2 cycles.
- Push DEPTH bytes with out_ready = 0 -> in_ready = 0 once count = DEPTH; extra in_valid bytes are not lost, and no overflow occurs after the handshake resumes.
- Flush with flush_pc = 16'h8000 while in S_HI (and separately in S_OUT with out_ready = 1) -> next cycle out_valid = 0, FIFO empty. The next pushed instruction reports pc = 8000, and the pre-flush instruction never appears.
- rdy = 0 for 5 cycles mid-assembly with in_valid = 1 -> no state change, in_ready = 0. After rdy returns, assembly resumes with the correct bytes. Assert rst asynchronously mid-S_LO -> outputs zero before the next edge.
- With DECODE_QUEUE_COUNT_EN defined, accept 3 instructions, flush, accept 1 -> instr_count = 4.
